multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 158 +++++++++++++++
 tb/tb_multicycle_alu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith, bit-serial shifts, optional shift-add MUL (ALU_MUL_EN).
// Latency: 1 edge for ops 000-100, max(1,n) edges for shifts, WIDTH edges for MUL.
// Backpressure: BUSY high while iterating; START is ignored until the state returns to IDLE.
module multicycle_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             BUSY,
    output logic             DONE
);

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;
    logic [WIDTH-1:0] acc, mcand, mplier, acc_nxt;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH:0]   sum_w, diff_w;
    logic [SHW-1:0]   shamt, cnt;
    logic [WIDTH-1:0] op_res, work, work_sh;
    logic             op_carry, multi_shift, shift_left;

    always_comb begin
        sum_w    = {1'b0, DATA1} + {1'b0, DATA2};
        diff_w   = {1'b0, DATA1} - {1'b0, DATA2};
        shamt    = (DATA2[SHW-1:0] > SHW'(WIDTH)) ? SHW'(WIDTH) : DATA2[SHW-1:0];
        multi_shift = ((SELECT == 3'b101) || (SELECT == 3'b110)) && (shamt > SHW'(1));
        op_res   = '0;
        op_carry = 1'b0;
        // For shifts this is the first one-bit step; it is the final value only when n<=1.
        case (SELECT)
            3'b000: op_res = DATA2;
            3'b001: begin op_res = sum_w[WIDTH-1:0];  op_carry = sum_w[WIDTH];  end
            3'b010: op_res = DATA1 & DATA2;
            3'b011: op_res = DATA1 | DATA2;
            3'b100: begin op_res = diff_w[WIDTH-1:0]; op_carry = diff_w[WIDTH]; end
            3'b101: op_res = (shamt == '0) ? DATA1 : (DATA1 << 1);
            3'b110: op_res = (shamt == '0) ? DATA1 : (DATA1 >> 1);
            default: op_res = '0;
        endcase
        work_sh = shift_left ? (work << 1) : (work >> 1);
`ifdef ALU_MUL_EN
        acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    if (multi_shift) state_nxt = ST_SHIFT;
`ifdef ALU_MUL_EN
                    else if (SELECT == 3'b111) state_nxt = ST_MUL;
`endif
                end
            end
            ST_SHIFT: if (cnt == SHW'(1)) state_nxt = ST_IDLE;
`ifdef ALU_MUL_EN
            ST_MUL:   if (cnt == SHW'(1)) state_nxt = ST_IDLE;
`endif
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RESULT     <= '0;
            ZERO       <= 1'b1;
            CARRY      <= 1'b0;
            DONE       <= 1'b0;
            cnt        <= '0;
            work       <= '0;
            shift_left <= 1'b0;
`ifdef ALU_MUL_EN
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        if (multi_shift) begin
                            work       <= op_res;
                            cnt        <= shamt - SHW'(1);
                            shift_left <= (SELECT == 3'b101);
                        end
`ifdef ALU_MUL_EN
                        else if (SELECT == 3'b111) begin
                            // Multiplier bit 0 is consumed on the accept edge.
                            acc    <= DATA2[0] ? DATA1 : '0;
                            mcand  <= DATA1 << 1;
                            mplier <= DATA2 >> 1;
                            cnt    <= SHW'(WIDTH - 1);
                        end
`endif
                        else begin
                            RESULT <= op_res;
                            ZERO   <= (op_res == '0);
                            CARRY  <= op_carry;
                            DONE   <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt == SHW'(1)) begin
                        RESULT <= work_sh;
                        ZERO   <= (work_sh == '0);
                        CARRY  <= 1'b0;
                        DONE   <= 1'b1;
                    end else begin
                        work <= work_sh;
                        cnt  <= cnt - SHW'(1);
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    if (cnt == SHW'(1)) begin
                        RESULT <= acc_nxt;
                        ZERO   <= (acc_nxt == '0);
                        CARRY  <= 1'b0;
                        DONE   <= 1'b1;
                    end else begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - SHW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (WIDTH=8) with an expected-result queue.
module tb_multicycle_alu;
    logic       CLK = 1'b0;
    logic       RESET, START;
    logic [7:0] DATA1, DATA2, RESULT;
    logic [2:0] SELECT;
    logic       ZERO, CARRY, BUSY, DONE;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       c;
        int         k;
        int         busy;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    multicycle_alu #(.WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
        .SELECT(SELECT), .RESULT(RESULT), .ZERO(ZERO), .CARRY(CARRY), .BUSY(BUSY), .DONE(DONE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for DONE, then compare against the queued expectation.
    task automatic issue(input string tag, input logic [2:0] sel, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] r, input logic c, input int k);
        exp_t e;
        int   n, busy;
        bit   got;
        e.res = r; e.z = (r == 8'h00); e.c = c; e.k = k; e.busy = k - 1;
        sb.push_back(e);
        @(negedge CLK);
        SELECT = sel; DATA1 = d1; DATA2 = d2; START = 1'b1;
        n = 0; busy = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge CLK); #1;
            n++;
            START = 1'b0;
            if (BUSY) busy++;
            if (DONE) got = 1'b1;
        end
        e = sb.pop_front();
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_result"}, 32'(RESULT), 32'(e.res));
        check({tag, "_zero"}, 32'(ZERO), 32'(e.z));
        check({tag, "_carry"}, 32'(CARRY), 32'(e.c));
        check({tag, "_latency"}, 32'(n), 32'(e.k));
        check({tag, "_busy_cycles"}, 32'(busy), 32'(e.busy));
        @(posedge CLK); #1;
        check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
        check({tag, "_hold"}, 32'(RESULT), 32'(e.res));
    endtask

    // Start a multi-cycle op, reset at edge 4, then confirm no DONE and reset outputs.
    task automatic abort_test(input string tag, input logic [2:0] sel, input logic [7:0] d1,
                              input logic [7:0] d2);
        int dones = 0;
        @(negedge CLK);
        SELECT = sel; DATA1 = d1; DATA2 = d2; START = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            if (DONE) dones++;
        end
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        if (DONE) dones++;
        RESET = 1'b0;
        check({tag, "_no_done"}, 32'(dones), 32'd0);
        check({tag, "_result"}, 32'(RESULT), 32'h00);
        check({tag, "_zero"}, 32'(ZERO), 32'd1);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        issue({tag, "_add_after"}, 3'b001, 8'h01, 8'h01, 8'h02, 1'b0, 1);
    endtask

    initial begin
        logic [2:0] b_sel [4];
        logic [7:0] b_d1 [4];
        logic [7:0] b_d2 [4];
        logic [7:0] b_res [4];
        logic       b_c   [4];
        exp_t       e;
        int         dones, n, first_k;
        logic [7:0] sll_res;

        RESET = 1'b1; START = 1'b0; SELECT = 3'b000; DATA1 = 8'h00; DATA2 = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_result", 32'(RESULT), 32'h00);
        check("rst_zero", 32'(ZERO), 32'd1);
        check("rst_carry", 32'(CARRY), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        RESET = 1'b0;

        issue("add_carry", 3'b001, 8'hF0, 8'h20, 8'h10, 1'b1, 1);
        issue("sub_equal", 3'b100, 8'h05, 8'h05, 8'h00, 1'b0, 1);
        issue("sub_borrow", 3'b100, 8'h03, 8'h05, 8'hFE, 1'b1, 1);
        issue("fwd", 3'b000, 8'h11, 8'hA5, 8'hA5, 1'b0, 1);
        issue("and", 3'b010, 8'hCC, 8'hAA, 8'h88, 1'b0, 1);
        issue("sll_by0", 3'b101, 8'h5A, 8'h00, 8'h5A, 1'b0, 1);
        issue("sll_by1", 3'b101, 8'h81, 8'h01, 8'h02, 1'b0, 1);
        issue("sll_by3", 3'b101, 8'h01, 8'h03, 8'h08, 1'b0, 3);
        issue("srl_by9", 3'b110, 8'h80, 8'h09, 8'h00, 1'b0, 8);
        issue("srl_by2", 3'b110, 8'hF0, 8'h12, 8'h3C, 1'b0, 2);
`ifdef ALU_MUL_EN
        issue("mul_13x11", 3'b111, 8'd13, 8'd11, 8'h8F, 1'b0, 8);
        issue("mul_ffxff", 3'b111, 8'hFF, 8'hFF, 8'h01, 1'b0, 8);
`else
        issue("mul_off", 3'b111, 8'd13, 8'd11, 8'h00, 1'b0, 1);
`endif

        issue("pre_abort", 3'b011, 8'h40, 8'h02, 8'h42, 1'b0, 1);
        abort_test("abort_shift", 3'b101, 8'h01, 8'h07);
`ifdef ALU_MUL_EN
        abort_test("abort_mul", 3'b111, 8'hFF, 8'hFF);
`endif

        // Back-to-back single-cycle requests with START held high.
        b_sel = '{3'b000, 3'b010, 3'b011, 3'b001};
        b_d1  = '{8'h00, 8'hF0, 8'h0F, 8'hFF};
        b_d2  = '{8'h3C, 8'h3C, 8'h30, 8'h01};
        b_res = '{8'h3C, 8'h30, 8'h3F, 8'h00};
        b_c   = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            e.res = b_res[i]; e.z = (b_res[i] == 8'h00); e.c = b_c[i]; e.k = 1; e.busy = 0;
            sb.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            SELECT = b_sel[i]; DATA1 = b_d1[i]; DATA2 = b_d2[i]; START = 1'b1;
            @(posedge CLK); #1;
            e = sb.pop_front();
            check($sformatf("b2b%0d_done", i), 32'(DONE), 32'd1);
            check($sformatf("b2b%0d_result", i), 32'(RESULT), 32'(e.res));
            check($sformatf("b2b%0d_zero", i), 32'(ZERO), 32'(e.z));
            check($sformatf("b2b%0d_carry", i), 32'(CARRY), 32'(e.c));
        end
        @(negedge CLK);
        START = 1'b0;

        // START held with an OR request while SLL by 5 runs: must be ignored.
        @(negedge CLK);
        SELECT = 3'b101; DATA1 = 8'h03; DATA2 = 8'h05; START = 1'b1;
        dones = 0; first_k = 0; sll_res = 8'h00;
        @(posedge CLK); #1;
        n = 1;
        if (DONE) begin dones++; first_k = n; sll_res = RESULT; end
        SELECT = 3'b011; DATA1 = 8'h0F; DATA2 = 8'hF0;
        repeat (10) begin
            @(posedge CLK); #1;
            n++;
            if (DONE) begin
                dones++; first_k = n; sll_res = RESULT; START = 1'b0;
            end
        end
        START = 1'b0;
        check("ignore_done_count", 32'(dones), 32'd1);
        check("ignore_latency", 32'(first_k), 32'd5);
        check("ignore_result", 32'(sll_res), 32'h60);
        check("ignore_hold", 32'(RESULT), 32'h60);
        check("ignore_busy", 32'(BUSY), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
